// File: rtl/sprite_anim_engine_pkg.sv
// Shared types and per-state sprite sheet geometry for the fighter sprite engine.
// Frame sizes are precomputed constants so the sequencer only ever adds them.
package sprite_pkg;

  localparam int N_ANIM  = 6;
  localparam int STATE_W = $clog2(N_ANIM);

  typedef enum logic [STATE_W-1:0] {
    ST_STAND   = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_MOVEL   = 3'd2,
    ST_MOVER   = 3'd3,
    ST_DEFENSE = 3'd4,
    ST_HURT    = 3'd5
  } anim_state_t;

  function automatic logic [9:0] st_width(input anim_state_t s);
    case (s)
      ST_ATTACK: st_width = 10'd48;
      ST_HURT:   st_width = 10'd40;
      default:   st_width = 10'd37;
    endcase
  endfunction

  function automatic logic [9:0] st_height(input anim_state_t s);
    case (s)
      ST_STAND: st_height = 10'd51;
      default:  st_height = 10'd51;
    endcase
  endfunction

  function automatic logic [7:0] st_frames(input anim_state_t s);
    case (s)
      ST_STAND:   st_frames = 8'd6;
      ST_ATTACK:  st_frames = 8'd4;
      ST_MOVEL:   st_frames = 8'd6;
      ST_MOVER:   st_frames = 8'd6;
      ST_DEFENSE: st_frames = 8'd3;
      ST_HURT:    st_frames = 8'd3;
      default:    st_frames = 8'd1;
    endcase
  endfunction

  // Words per frame (width * height), kept as literals.
  function automatic logic [18:0] st_fsize(input anim_state_t s);
    case (s)
      ST_ATTACK: st_fsize = 19'd2448;
      ST_HURT:   st_fsize = 19'd2040;
      default:   st_fsize = 19'd1887;
    endcase
  endfunction

  // States are packed back to back in the unified ROM.
  function automatic logic [18:0] st_base(input anim_state_t s);
    case (s)
      ST_STAND:   st_base = 19'd0;
      ST_ATTACK:  st_base = 19'd11322;
      ST_MOVEL:   st_base = 19'd21114;
      ST_MOVER:   st_base = 19'd32436;
      ST_DEFENSE: st_base = 19'd43758;
      ST_HURT:    st_base = 19'd49419;
      default:    st_base = 19'd0;
    endcase
  endfunction

  function automatic logic st_loop(input anim_state_t s);
    case (s)
      ST_ATTACK: st_loop = 1'b0;
      ST_HURT:   st_loop = 1'b0;
      default:   st_loop = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sprite_anim_engine_rom.sv
// Single-port synchronous sprite ROM; the image is a fixed address-derived pattern
// (low address byte XOR 8'h15), zero beyond ROM_DEPTH. Output clears when en is low.
module sprite_rom #(
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 19,
  parameter int ROM_DEPTH = 87000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  q
);

  function automatic logic [PIX_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [7:0] w;
    w = a[7:0] ^ 8'h15;
    if ({1'b0, a} < (ADDR_W+1)'(ROM_DEPTH)) rom_word = PIX_W'(w);
    else rom_word = '0;
  endfunction

  // Registered read, gated so out-of-box pixels read as zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) q <= '0;
    else if (en) q <= rom_word(addr);
    else q <= '0;
  end

endmodule

// File: rtl/sprite_anim_engine.sv
// Per-fighter sprite animation sequencer plus 3-stage pixel pipeline.
// Optional horizontal mirroring is enabled with the SPRITE_MIRROR_EN macro.
module sprite_anim_engine
  import sprite_pkg::*;
#(
  parameter int               PIX_W           = 8,
  parameter int               ADDR_W          = 19,
  parameter int               N_STATES        = 6,
  parameter int               FRAME_DIV       = 4,
  parameter int               SCALE_SHIFT     = 1,
  parameter logic [PIX_W-1:0] TRANSPARENT_IDX = 8'h00,
  parameter int               ROM_DEPTH       = 87000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [STATE_W-1:0] anim_state,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               facing_left,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic               is_character,
  output logic [PIX_W-1:0]   data_Out,
  output logic [7:0]         frame_idx,
  output logic               anim_done
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [2:0]        fsync_r;
  logic              tick_s;
  anim_state_t       cur_state_r, next_state_s, req_state_s;
  logic [7:0]        frame_idx_r, frame_idx_s;
  logic [ADDR_W-1:0] frame_base_r, frame_base_s;
  logic [DIV_W-1:0]  div_cnt_r, div_cnt_s;
  logic              done_hold_r, done_hold_s;
  logic              anim_done_r, anim_done_s;
  logic [9:0]        pos_x_r, pos_y_r;

  // frame_clk synchroniser; bit 2 remembers the previous synchronised level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) fsync_r <= 3'b000;
    else fsync_r <= {fsync_r[1:0], frame_clk};
  end

  assign tick_s = fsync_r[1] & ~fsync_r[2];

  // Out-of-range requests fall back to standing.
  always_comb begin
    req_state_s = ST_STAND;
    if (int'(anim_state) < N_STATES) req_state_s = anim_state_t'(anim_state);
    else req_state_s = ST_STAND;
  end

  // Sequencer state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_state_r  <= ST_STAND;
      frame_idx_r  <= 8'd0;
      frame_base_r <= ADDR_W'(st_base(ST_STAND));
      div_cnt_r    <= '0;
      done_hold_r  <= 1'b0;
      anim_done_r  <= 1'b0;
    end else begin
      cur_state_r  <= next_state_s;
      frame_idx_r  <= frame_idx_s;
      frame_base_r <= frame_base_s;
      div_cnt_r    <= div_cnt_s;
      done_hold_r  <= done_hold_s;
      anim_done_r  <= anim_done_s;
    end
  end

  // Sequencer next-state: state switch, frame divider and loop/one-shot handling.
  always_comb begin
    next_state_s = cur_state_r;
    frame_idx_s  = frame_idx_r;
    frame_base_s = frame_base_r;
    div_cnt_s    = div_cnt_r;
    done_hold_s  = done_hold_r;
    anim_done_s  = 1'b0;
    if (tick_s) begin
      if (req_state_s != cur_state_r) begin
        next_state_s = req_state_s;
        frame_idx_s  = 8'd0;
        div_cnt_s    = '0;
        frame_base_s = ADDR_W'(st_base(req_state_s));
        done_hold_s  = 1'b0;
      end else if (div_cnt_r == DIV_W'(FRAME_DIV - 1)) begin
        div_cnt_s = '0;
        if (done_hold_r) begin
          frame_idx_s = frame_idx_r;
        end else if (frame_idx_r != st_frames(cur_state_r) - 8'd1) begin
          frame_idx_s  = frame_idx_r + 8'd1;
          frame_base_s = frame_base_r + ADDR_W'(st_fsize(cur_state_r));
        end else if (st_loop(cur_state_r)) begin
          frame_idx_s  = 8'd0;
          frame_base_s = ADDR_W'(st_base(cur_state_r));
        end else begin
          anim_done_s = 1'b1;
          done_hold_s = 1'b1;
        end
      end else begin
        div_cnt_s = div_cnt_r + DIV_W'(1);
      end
    end else begin
      anim_done_s = 1'b0;
    end
  end

  // Position is only sampled on the frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_r <= 10'd0;
      pos_y_r <= 10'd0;
    end else if (tick_s) begin
      pos_x_r <= pos_x;
      pos_y_r <= pos_y;
    end
  end

  logic [10:0]       dx_s, dy_s, box_w_s, box_h_s;
  logic              in_box_s;
  logic [9:0]        dx0_r, dy0_r;
  logic              in_box0_r, in_box1_r;
  anim_state_t       state0_r;
  logic [ADDR_W-1:0] base0_r, addr_s, addr1_r;
  logic [9:0]        w1_s, sx_raw_s, sy_s, sx_s;
  logic [PIX_W-1:0]  rom_q_s;

  // Bit 10 is the sign: DrawX left of pos_x never wraps into the box.
  assign dx_s     = {1'b0, DrawX} - {1'b0, pos_x_r};
  assign dy_s     = {1'b0, DrawY} - {1'b0, pos_y_r};
  assign box_w_s  = 11'(st_width(cur_state_r)) << SCALE_SHIFT;
  assign box_h_s  = 11'(st_height(cur_state_r)) << SCALE_SHIFT;
  assign in_box_s = !dx_s[10] && !dy_s[10] && (dx_s < box_w_s) && (dy_s < box_h_s);

  // S0: offsets plus a snapshot of the sequencer so a tick cannot tear a pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dx0_r     <= 10'd0;
      dy0_r     <= 10'd0;
      in_box0_r <= 1'b0;
      state0_r  <= ST_STAND;
      base0_r   <= '0;
    end else begin
      dx0_r     <= dx_s[9:0];
      dy0_r     <= dy_s[9:0];
      in_box0_r <= in_box_s;
      state0_r  <= cur_state_r;
      base0_r   <= frame_base_r;
    end
  end

  assign w1_s     = st_width(state0_r);
  assign sx_raw_s = dx0_r >> SCALE_SHIFT;
  assign sy_s     = dy0_r >> SCALE_SHIFT;

`ifdef SPRITE_MIRROR_EN
  logic mirror_r, mirror0_r;

  // Facing is latched with the position and snapshotted alongside the frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mirror_r  <= 1'b0;
      mirror0_r <= 1'b0;
    end else begin
      mirror_r  <= tick_s ? facing_left : mirror_r;
      mirror0_r <= mirror_r;
    end
  end

  assign sx_s = mirror0_r ? (w1_s - 10'd1 - sx_raw_s) : sx_raw_s;
`else
  logic unused_facing_s;
  assign unused_facing_s = facing_left;
  assign sx_s = sx_raw_s;
`endif

  assign addr_s = in_box0_r ? (base0_r + ADDR_W'(sy_s) * ADDR_W'(w1_s) + ADDR_W'(sx_s))
                            : '0;

  // S1: ROM address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr1_r   <= '0;
      in_box1_r <= 1'b0;
    end else begin
      addr1_r   <= addr_s;
      in_box1_r <= in_box0_r;
    end
  end

  sprite_rom #(
    .PIX_W    (PIX_W),
    .ADDR_W   (ADDR_W),
    .ROM_DEPTH(ROM_DEPTH)
  ) u_rom (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .en     (in_box1_r),
    .addr   (addr1_r),
    .q      (rom_q_s)
  );

  logic in_box2_r;

  // S2: box flag aligned with the ROM word.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) in_box2_r <= 1'b0;
    else in_box2_r <= in_box1_r;
  end

  assign data_Out     = rom_q_s;
  assign is_character = in_box2_r && (rom_q_s != TRANSPARENT_IDX);
  assign frame_idx    = frame_idx_r;
  assign anim_done    = anim_done_r;

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Self-checking bench for sprite_anim_engine: directed steps followed by random
// ticks/probes, all compared against a tick-count based reference model.
module tb_sprite_anim_engine;

  localparam int FDIV  = 4;
  localparam int SC    = 2;
  localparam int DEPTH = 87000;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic [2:0] anim_state = 3'd0;
  logic [9:0] pos_x = 10'd0, pos_y = 10'd0, DrawX = 10'd0, DrawY = 10'd0;
  logic       facing_left = 1'b0;
  logic       is_character, anim_done;
  logic [7:0] data_Out, frame_idx;

  sprite_anim_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .anim_state(anim_state),
    .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left),
    .DrawX(DrawX), .DrawY(DrawY), .is_character(is_character),
    .data_Out(data_Out), .frame_idx(frame_idx), .anim_done(anim_done)
  );

  always #10 Clk = ~Clk;

  int done_cnt = 0;
  always @(negedge Clk) if (anim_done === 1'b1) done_cnt++;

  int tw[6] = '{37, 48, 37, 37, 37, 40};
  int th[6] = '{51, 51, 51, 51, 51, 51};
  int tf[6] = '{6, 4, 6, 6, 3, 3};
  int tl[6] = '{1, 0, 1, 1, 1, 0};
  int tbase[6];

  int m_st, m_n, m_px, m_py, m_face, exp_done;
  int n_asrt = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_idx();
    int k;
    k = m_n / FDIV;
    if (tl[m_st] == 1) return k % tf[m_st];
    else return (k < tf[m_st]) ? k : tf[m_st] - 1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_n = 0; m_px = 0; m_py = 0; m_face = 0;
  endtask

  task automatic do_tick(input int st, input int px, input int py, input int face);
    int req;
    @(negedge Clk);
    anim_state = 3'(st); pos_x = 10'(px); pos_y = 10'(py); facing_left = face[0];
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    req = (st >= 6) ? 0 : st;
    m_px = px; m_py = py; m_face = face;
    if (req != m_st) begin
      m_st = req; m_n = 0;
    end else begin
      m_n++;
      if (tl[m_st] == 0 && m_n == tf[m_st] * FDIV) exp_done++;
    end
    chk("frame_idx", 32'(frame_idx), 32'(m_idx()));
    chk("anim_done_pulses", 32'(done_cnt), 32'(exp_done));
  endtask

  task automatic probe(input int x, input int y, input string tag);
    int dx, dy, sx, sy, addr, ed, ec, inb;
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y);
    repeat (3) @(posedge Clk);
    #1;
    dx = x - m_px; dy = y - m_py;
    inb = (dx >= 0 && dy >= 0 && dx < tw[m_st] * SC && dy < th[m_st] * SC) ? 1 : 0;
    sx = dx / SC; sy = dy / SC;
`ifdef SPRITE_MIRROR_EN
    if (m_face != 0) sx = tw[m_st] - 1 - sx;
`endif
    addr = (tbase[m_st] + m_idx() * tw[m_st] * th[m_st] + sy * tw[m_st] + sx) % (1 << 19);
    ed = (inb != 0 && addr < DEPTH) ? ((addr % 256) ^ 'h15) : 0;
    ec = (inb != 0 && ed != 0) ? 1 : 0;
    chk({tag, "_data"}, 32'(data_Out), 32'(ed));
    chk({tag, "_char"}, 32'(is_character), 32'(ec));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_char"}, 32'(is_character), 32'd0);
    chk({tag, "_data"}, 32'(data_Out), 32'd0);
    chk({tag, "_fidx"}, 32'(frame_idx), 32'd0);
    chk({tag, "_done"}, 32'(anim_done), 32'd0);
  endtask

  initial begin
    int st, px, py, x, y;
    tbase[0] = 0;
    for (int i = 1; i < 6; i++) tbase[i] = tbase[i-1] + tw[i-1] * th[i-1] * tf[i-1];
    model_reset();
    exp_done = 0;

    // reset held while the beam sweeps
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479));
      chk_zero("reset_sweep");
    end
    @(negedge Clk);
    Reset_n = 1'b1;

    // stand at (400,200): origin, scaled interior, left of box, transparent word
    do_tick(0, 400, 200, 0);
    probe(400, 200, "origin");
    probe(402, 202, "scaled");
    probe(399, 200, "left_edge");
    probe(400 + 42, 200, "transparent");
    probe(400 + 73, 200 + 101, "last_pixel");
    probe(400 + 74, 200, "right_edge");
    probe(400, 200 + 102, "bottom_edge");

    // frame advance and loop wrap
    repeat (3) do_tick(0, 400, 200, 0);
    probe(400, 200, "frame1");
    repeat (20) do_tick(0, 400, 200, 0);
    probe(400, 200, "wrapped");

    // one-shot attack then back to stand
    do_tick(1, 100, 50, 1);
    repeat (20) do_tick(1, 100, 50, 1);
    probe(110, 60, "attack_last");
    do_tick(0, 100, 50, 1);
    probe(100, 50, "mirror_or_not");
    do_tick(7, 630, 470, 0);
    probe(639, 479, "clip");

    // async reset in the middle of operation
    repeat (5) do_tick(3, 300, 300, 0);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1 chk_zero("mid_reset");
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    probe(0, 0, "post_reset");

    // random operation
    st = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 4) == 0) st = int'($urandom_range(0, 7));
        px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479));
        do_tick(st, px, py, int'($urandom_range(0, 1)));
      end else begin
        x = m_px + int'($urandom_range(0, 110)) - 8;
        y = m_py + int'($urandom_range(0, 118)) - 8;
        x = (x < 0) ? 0 : (x > 1023 ? 1023 : x);
        y = (y < 0) ? 0 : (y > 1023 ? 1023 : y);
        probe(x, y, "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
